// File: rtl/async_fifo_pkg.sv
// Shared constants and Gray-code helpers for both sides of the async FIFO.
package async_fifo_pkg;

    localparam int unsigned ADDRSIZE_DEFAULT = 4;
    localparam int unsigned CONV_W           = 32;

    // Binary to reflected Gray code; callers zero-extend into CONV_W bits.
    function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Gray to binary by XOR prefix from the MSB down.
    function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] gray);
        logic [CONV_W-1:0] bin;
        bin[CONV_W-1] = gray[CONV_W-1];
        for (int i = int'(CONV_W) - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/wptr_full_ctrl_gray2bin.sv
// Width-parameterized Gray to binary converter (combinational XOR prefix chain).
module gray2bin #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        logic [WIDTH-1:0] acc;
        acc[WIDTH-1] = gray_i[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            acc[i] = acc[i+1] ^ gray_i[i];
        end
        bin_o = acc;
    end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer, full/almost-full, fill level and sticky overflow for an async FIFO.
module wptr_full_ctrl
    import async_fifo_pkg::*;
#(
    parameter int unsigned ADDRSIZE = ADDRSIZE_DEFAULT
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   afull_thresh,
    input  logic                wclr_ovf,
    output logic                wfull,
    output logic                wafull,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                woverflow
);

    localparam int unsigned PW = ADDRSIZE + 1;

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] wlevel_q, wlevel_d;
    logic [PW-1:0] rbin;
    logic          wfull_q, wfull_d;
    logic          wafull_q, wafull_d;
    logic          wovf_q, wovf_d;
    logic          wen;

    gray2bin #(
        .WIDTH (PW)
    ) u_rptr_g2b (
        .gray_i (wq2_rptr),
        .bin_o  (rbin)
    );

    // Next pointer, flags and level; full compares against the read pointer one lap behind.
    always_comb begin
        wen      = winc & ~wfull_q;
        wbin_d   = wbin_q + PW'(wen);
        wptr_d   = PW'(bin2gray(CONV_W'(wbin_d)));
        wfull_d  = (wptr_d == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
        wlevel_d = wbin_d - rbin;
        wafull_d = (wlevel_d >= afull_thresh);
        // A write attempt against a full FIFO outranks a same-cycle clear.
        wovf_d   = (winc & wfull_q) | (wovf_q & ~wclr_ovf);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wlevel_q <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wlevel_q <= wlevel_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wovf_q   <= wovf_d;
        end
    end

    assign waddr     = wbin_q[ADDRSIZE-1:0];
    assign wptr      = wptr_q;
    assign wlevel    = wlevel_q;
    assign wfull     = wfull_q;
    assign wafull    = wafull_q;
    assign woverflow = wovf_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Bench for wptr_full_ctrl (ADDRSIZE=4): directed scenarios plus random traffic vs a count-based model.
module tb_wptr_full_ctrl;

    logic       wclk = 1'b0;
    logic       wrst = 1'b1;
    logic [4:0] wq2_rptr = '0;
    logic       winc = 1'b0;
    logic [4:0] afull_thresh = 5'd17;
    logic       wclr_ovf = 1'b0;
    logic       wfull, wafull, woverflow;
    logic [3:0] waddr;
    logic [4:0] wptr, wlevel;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Model: total words written / read since reset, plus registered flags.
    int unsigned m_wr, m_rd, m_level;
    bit          m_full, m_afull, m_ovf;

    wptr_full_ctrl #(.ADDRSIZE(4)) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .wq2_rptr     (wq2_rptr),
        .winc         (winc),
        .afull_thresh (afull_thresh),
        .wclr_ovf     (wclr_ovf),
        .wfull        (wfull),
        .wafull       (wafull),
        .waddr        (waddr),
        .wptr         (wptr),
        .wlevel       (wlevel),
        .woverflow    (woverflow)
    );

    always #5 wclk = ~wclk;

    function automatic logic [4:0] g5(input int unsigned b);
        logic [4:0] x;
        x = 5'(b % 32);
        return x ^ (x >> 1);
    endfunction

    // Apply one cycle of inputs, advance the model, sample #1 after the edge.
    task automatic drive(input bit w, input int unsigned rd, input bit clr);
        bit acc;
        winc     = w;
        wq2_rptr = g5(rd);
        wclr_ovf = clr;
        acc      = w && !m_full;
        m_ovf    = (w && m_full) || (m_ovf && !clr);
        m_wr     = m_wr + (acc ? 1 : 0);
        m_rd     = rd;
        m_level  = (m_wr - m_rd) % 32;
        m_full   = (m_level == 16);
        m_afull  = (m_level >= int'(afull_thresh));
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        wrst = 1'b1;
        winc = 1'b1;
        wq2_rptr = '0;
        wclr_ovf = 1'b0;
        @(posedge wclk);
        #1;
        wrst = 1'b0;
        winc = 1'b0;
        m_wr = 0; m_rd = 0; m_level = 0;
        m_full = 0; m_afull = 0; m_ovf = 0;
    endtask

    task automatic test_reset();
        wrst = 1'b1;
        winc = 1'b1;
        @(posedge wclk);
        #1;
        n_cmp++;
        if ({wfull, wafull, waddr, wptr, wlevel, woverflow} !== 17'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {wfull, wafull, waddr, wptr, wlevel, woverflow});
        end
        do_reset();
        winc = 1'b1;
        n_cmp++;
        if (waddr !== 4'd0) begin
            n_err++;
            $display("FAIL reset_first_addr: got %0d expected 0", waddr);
        end
        drive(1, 0, 0);
        n_cmp++;
        if (waddr !== 4'd1 || wptr !== 5'b00001) begin
            n_err++;
            $display("FAIL reset_first_write: got waddr=%0d wptr=%b expected 1/00001", waddr, wptr);
        end
    endtask

    task automatic test_fill();
        do_reset();
        afull_thresh = 5'd17;
        for (int i = 0; i < 15; i++) drive(1, 0, 0);
        n_cmp++;
        if (wfull !== 1'b0 || wlevel !== 5'd15) begin
            n_err++;
            $display("FAIL fill_15: got wfull=%b wlevel=%0d expected 0/15", wfull, wlevel);
        end
        drive(1, 0, 0);
        n_cmp++;
        if (wfull !== 1'b1 || wptr !== 5'b11000 || waddr !== 4'd0 || wlevel !== 5'd16 || wafull !== 1'b0) begin
            n_err++;
            $display("FAIL fill_16: got wfull=%b wptr=%b waddr=%0d wlevel=%0d wafull=%b expected 1/11000/0/16/0",
                     wfull, wptr, waddr, wlevel, wafull);
        end
    endtask

    task automatic test_overflow();
        drive(1, 0, 0);
        n_cmp++;
        if (wptr !== 5'b11000 || woverflow !== 1'b1 || wlevel !== 5'd16 || waddr !== 4'd0) begin
            n_err++;
            $display("FAIL ovf_set: got wptr=%b woverflow=%b wlevel=%0d waddr=%0d expected 11000/1/16/0",
                     wptr, woverflow, wlevel, waddr);
        end
        drive(0, 0, 1);
        n_cmp++;
        if (woverflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear: got %b expected 0", woverflow);
        end
        drive(1, 0, 1);
        n_cmp++;
        if (woverflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set_wins: got %b expected 1", woverflow);
        end
    endtask

    task automatic test_simultaneous();
        drive(1, 1, 0);
        n_cmp++;
        if (wfull !== 1'b0 || wlevel !== 5'd15 || wptr !== 5'b11000) begin
            n_err++;
            $display("FAIL simul_blocked: got wfull=%b wlevel=%0d wptr=%b expected 0/15/11000", wfull, wlevel, wptr);
        end
        drive(1, 1, 0);
        n_cmp++;
        if (wfull !== 1'b1 || wlevel !== 5'd16 || wptr !== 5'b11001) begin
            n_err++;
            $display("FAIL simul_accept: got wfull=%b wlevel=%0d wptr=%b expected 1/16/11001", wfull, wlevel, wptr);
        end
    endtask

    task automatic test_afull();
        do_reset();
        afull_thresh = 5'd12;
        for (int i = 0; i < 11; i++) drive(1, 0, 0);
        n_cmp++;
        if (wafull !== 1'b0 || wlevel !== 5'd11) begin
            n_err++;
            $display("FAIL afull_11: got wafull=%b wlevel=%0d expected 0/11", wafull, wlevel);
        end
        drive(1, 0, 0);
        n_cmp++;
        if (wafull !== 1'b1 || wlevel !== 5'd12) begin
            n_err++;
            $display("FAIL afull_12: got wafull=%b wlevel=%0d expected 1/12", wafull, wlevel);
        end
        do_reset();
        afull_thresh = 5'd0;
        drive(0, 0, 0);
        n_cmp++;
        if (wafull !== 1'b1) begin
            n_err++;
            $display("FAIL afull_zero: got %b expected 1", wafull);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        afull_thresh = 5'd17;
        for (int i = 0; i < 16; i++) drive(1, 0, 0);
        drive(0, 16, 0);
        n_cmp++;
        if (wlevel !== 5'd0 || wfull !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_drain: got wlevel=%0d wfull=%b expected 0/0", wlevel, wfull);
        end
        for (int i = 1; i <= 16; i++) begin
            drive(1, 16, 0);
            n_cmp++;
            if (wlevel !== 5'(i) || wfull !== (i == 16) || wafull !== 1'b0) begin
                n_err++;
                $display("FAIL wrap_step%0d: got wlevel=%0d wfull=%b wafull=%b expected %0d/%0b/0",
                         i, wlevel, wfull, wafull, i, (i == 16));
            end
        end
        n_cmp++;
        if (wptr !== 5'b00000 || waddr !== 4'd0) begin
            n_err++;
            $display("FAIL wrap_ptr: got wptr=%b waddr=%0d expected 00000/0", wptr, waddr);
        end
    endtask

    task automatic test_reset_midburst();
        do_reset();
        for (int i = 0; i < 5; i++) drive(1, 0, 0);
        #2;
        wrst = 1'b1;
        #1;
        n_cmp++;
        if ({wfull, wafull, waddr, wptr, wlevel, woverflow} !== 17'd0) begin
            n_err++;
            $display("FAIL midburst_async: got %b expected all zero",
                     {wfull, wafull, waddr, wptr, wlevel, woverflow});
        end
        winc = 1'b1;
        @(posedge wclk);
        #1;
        n_cmp++;
        if (waddr !== 4'd0 || wptr !== 5'd0) begin
            n_err++;
            $display("FAIL midburst_hold: got waddr=%0d wptr=%b expected 0/00000", waddr, wptr);
        end
        wrst = 1'b0;
        m_wr = 0; m_rd = 0; m_level = 0;
        m_full = 0; m_afull = 0; m_ovf = 0;
        drive(1, 0, 0);
        n_cmp++;
        if (waddr !== 4'd1 || wptr !== 5'b00001 || wlevel !== 5'd1) begin
            n_err++;
            $display("FAIL midburst_first: got waddr=%0d wptr=%b wlevel=%0d expected 1/00001/1", waddr, wptr, wlevel);
        end
    endtask

    task automatic test_random();
        int unsigned rd;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if (c % 200 == 0) afull_thresh = 5'($urandom_range(18, 0));
            rd = m_rd;
            if ($urandom_range(2, 0) == 0) rd = m_rd + $urandom_range(m_wr - m_rd, 0);
            drive($urandom_range(3, 0) != 0, rd, $urandom_range(7, 0) == 0);
            n_cmp++;
            if (wfull !== m_full) begin
                n_err++;
                $display("FAIL rand_wfull c=%0d: got %b expected %b", c, wfull, m_full);
            end
            n_cmp++;
            if (wafull !== m_afull) begin
                n_err++;
                $display("FAIL rand_wafull c=%0d: got %b expected %b", c, wafull, m_afull);
            end
            n_cmp++;
            if (waddr !== 4'(m_wr % 16) || wptr !== g5(m_wr)) begin
                n_err++;
                $display("FAIL rand_ptr c=%0d: got waddr=%0d wptr=%b expected %0d/%b",
                         c, waddr, wptr, m_wr % 16, g5(m_wr));
            end
            n_cmp++;
            if (wlevel !== 5'(m_level)) begin
                n_err++;
                $display("FAIL rand_wlevel c=%0d: got %0d expected %0d", c, wlevel, m_level);
            end
            n_cmp++;
            if (woverflow !== m_ovf) begin
                n_err++;
                $display("FAIL rand_ovf c=%0d: got %b expected %b", c, woverflow, m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_simultaneous();
        test_afull();
        test_wrap();
        test_reset_midburst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wptr_full_ctrl.md
WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

Interface
REQ-001 The block SHALL have parameter ADDRSIZE, default 4, giving the FIFO address width; depth is 2^ADDRSIZE.
REQ-002 The block SHALL have port wclk, input, 1 bit: the write clock, and the only clock of the block.
REQ-003 The block SHALL have port wrst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port wq2_rptr, input, ADDRSIZE+1 bits: the Gray read pointer, already synchronized into wclk.
REQ-005 The block SHALL have port winc, input, 1 bit: write request.
REQ-006 The block SHALL have port afull_thresh, input, ADDRSIZE+1 bits: the almost-full fill threshold.
REQ-007 The block SHALL have port wclr_ovf, input, 1 bit: clears the sticky overflow flag.
REQ-008 The block SHALL have port wfull, output, 1 bit, registered: FIFO full.
REQ-009 The block SHALL have port wafull, output, 1 bit, registered: almost full.
REQ-010 The block SHALL have port waddr, output, ADDRSIZE bits: binary memory write address.
REQ-011 The block SHALL have port wptr, output, ADDRSIZE+1 bits, registered: Gray write pointer, sent to the read domain.
REQ-012 The block SHALL have port wlevel, output, ADDRSIZE+1 bits, registered: fill level as seen by the write side.
REQ-013 The block SHALL have port woverflow, output, 1 bit, registered: sticky flag, set when a write is attempted while full.

Function
REQ-014 The block SHALL hold the binary write pointer wbin, ADDRSIZE+1 bits, with wbinnext = wbin + (winc AND NOT wfull), wrapping modulo 2^(ADDRSIZE+1).
REQ-015 On every wclk edge the block SHALL register wbin <= wbinnext and wptr <= wgraynext, where wgraynext = (wbinnext >> 1) XOR wbinnext.
REQ-016 waddr SHALL equal wbin[ADDRSIZE-1:0], combinationally from the register.
REQ-017 A write SHALL be accepted in a cycle exactly when winc=1 and wfull=0 at that edge; the memory write-enable is winc AND NOT wfull.
REQ-018 wfull SHALL register (wgraynext == {NOT wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}), so it reflects the state after the write in that cycle.
REQ-019 wlevel SHALL register (wbinnext - gray2bin(wq2_rptr)) modulo 2^(ADDRSIZE+1); its range is 0..2^ADDRSIZE.
REQ-020 wafull SHALL register (next wlevel >= afull_thresh), compared unsigned.
REQ-021 afull_thresh=0 SHALL give wafull=1 at every edge after reset.
REQ-022 afull_thresh > 2^ADDRSIZE SHALL keep wafull=0.
REQ-023 woverflow SHALL set on an edge where winc=1 and wfull=1.
REQ-024 woverflow SHALL clear on an edge where wclr_ovf=1.
REQ-025 When woverflow set and clear occur in the same cycle, set SHALL win.
REQ-026 An attempted write while full SHALL leave wbin, wptr, waddr and wlevel unchanged.
REQ-027 When wq2_rptr advances in the same cycle as a blocked write, the write SHALL stay blocked, and wfull/wlevel SHALL update using the new wq2_rptr.
REQ-028 Pointer wrap from 2^(ADDRSIZE+1)-1 to 0 SHALL be seamless, with no glitch in full or level.

Reset
REQ-029 While wrst=1, the block SHALL force wbin=0, wptr=0, waddr=0, wfull=0, wafull=0, wlevel=0 and woverflow=0, asynchronously.
REQ-030 Reset asserted mid-burst SHALL discard the pointer state; the first edge after release with winc=1 SHALL write address 0.
REQ-031 While reset is asserted, winc SHALL be ignored.

Structure
REQ-032 Package async_fifo_pkg SHALL hold the ADDRSIZE default constant and the bin2gray/gray2bin functions, shared with the read-side logic.
REQ-033 One combinational sub-module, gray2bin (width-parameterized, XOR prefix chain), SHALL convert wq2_rptr; all other logic SHALL stay flat.

Verification (ADDRSIZE=4, depth 16)
REQ-034 Reset: wrst=1 with winc=1 -> all outputs 0; after release, first write goes to waddr=0.
REQ-035 Fill: wq2_rptr=0, winc=1 for 16 edges -> after edge 16, wfull=1, wptr=5'b11000, waddr=0, wlevel=16.
REQ-036 Overflow: full, winc=1 one more edge -> wptr stays 5'b11000 and woverflow=1; then wclr_ovf=1 with winc=0 -> woverflow=0; wclr_ovf=1 with winc=1 while full -> woverflow stays 1.
REQ-037 Almost-full: afull_thresh=12, wq2_rptr=0 -> wafull=0 after 11 writes, wafull=1 and wlevel=12 after write 12.
REQ-038 Wrap: wq2_rptr=5'b11000 (bin 16), 16 writes from bin 16 -> wbin wraps to 0, wptr=5'b00000, wfull=1, wlevel=16.
REQ-039 Simultaneous: full at bin 16, wq2_rptr changes 0 -> 5'b00001 with winc=1 -> write blocked, wfull=0 and wlevel=15 next edge; the following write is accepted and wfull=1 again.
